// File: rtl/can_pkg.sv
// Shared types and constants for the CAN bit-timing generator.
package can_pkg;

    // Segment the current time quantum belongs to
    typedef enum logic [1:0] {
        SEG_SYNC = 2'd0,
        SEG_1    = 2'd1,
        SEG_2    = 2'd2
    } can_seg_t;

    localparam int unsigned PRESC_W   = 6;
    localparam int unsigned TQ_W      = 5;
    localparam logic        RECESSIVE = 1'b1;

    function automatic logic [TQ_W-1:0] min_tq(input logic [TQ_W-1:0] a,
                                               input logic [TQ_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/can_bit_timing_if.sv
// Bus-side signals of the bit-timing generator: raw RX in, sample/sync strobes out.
interface can_bit_timing_if;
    logic RX;
    logic hard_sync_en;
    logic SP;
    logic sampled_bit;
    logic bit_start;
    logic resync_event;

    // Drives RX and hard-sync enable, consumes the timing strobes
    modport master (
        output RX,
        output hard_sync_en,
        input  SP,
        input  sampled_bit,
        input  bit_start,
        input  resync_event
    );

    // The bit-timing generator itself
    modport slave (
        input  RX,
        input  hard_sync_en,
        output SP,
        output sampled_bit,
        output bit_start,
        output resync_event
    );
endinterface

// File: rtl/can_rx_sync.sv
// Two-flop synchroniser for the asynchronous CAN RX line plus recessive->dominant
// edge detection on the synchronised value.
module can_rx_sync
    import can_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic edge_o
);

    // [0],[1] synchronise; [2] holds the previous synchronised value
    logic [2:0] sync_q, sync_d;

    // Shift the raw line through the chain
    always_comb begin
        sync_d = {sync_q[1:0], rx_i};
    end

    // Chain idles recessive so reset never produces a spurious edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {3{RECESSIVE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s_o = sync_q[1];
    assign edge_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing / sample-point generator: prescaler, SYNC/SEG1/SEG2 sequencing,
// hard sync and SJW-limited resynchronisation, sample-point pulse and sampled bit.
module can_bit_timing
    import can_pkg::*;
#(
    parameter int unsigned BRP   = 4,
    parameter int unsigned TSEG1 = 5,
    parameter int unsigned TSEG2 = 2,
    parameter int unsigned SJW   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    can_bit_timing_if.slave   bus
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(BRP - 1);
    localparam logic [TQ_W-1:0]    SEG1_NOM  = TQ_W'(TSEG1);
    localparam logic [TQ_W-1:0]    SEG2_NOM  = TQ_W'(TSEG2);
    localparam logic [TQ_W-1:0]    SJW_TQ    = TQ_W'(SJW);

    logic rx_s;
    logic fall_edge;

    can_rx_sync u_rx_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .rx_i    (bus.RX),
        .rx_s_o  (rx_s),
        .edge_o  (fall_edge)
    );

    can_seg_t            seg_q, seg_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [TQ_W-1:0]     tq_q, tq_d;
    logic [TQ_W-1:0]     seg1_len_q, seg1_len_d;
    logic [TQ_W-1:0]     seg2_len_q, seg2_len_d;
    logic                synced_q, synced_d;
    logic                sp_done_q, sp_done_d;
    logic                sp_q, sp_d;
    logic                bit_start_q, bit_start_d;
    logic                resync_q, resync_d;
    logic                sampled_q, sampled_d;

    logic                tick;
    logic                restart;
    logic                resync;
    logic                handled;
    logic                wrap;
    logic                entering_sync;
    logic [TQ_W-1:0]     rem;
    logic [TQ_W-1:0]     seg1_len_n;
    logic [TQ_W-1:0]     seg2_len_n;

    // Edge handling, segment sequencing and next values of the registered strobes
    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        rem        = seg2_len_q - tq_q;
        seg1_len_n = seg1_len_q;
        seg2_len_n = seg2_len_q;
        restart    = 1'b0;
        resync     = 1'b0;
        handled    = 1'b0;

        if (fall_edge && bus.hard_sync_en) begin
            restart = 1'b1;
            resync  = 1'b1;
            handled = 1'b1;
        end else if (fall_edge && !synced_q) begin
            // Edge in SYNC_SEG has zero phase error: only marks the bit as synced
            handled = 1'b1;
            case (seg_q)
                SEG_1: begin
                    seg1_len_n = SEG1_NOM + min_tq(tq_q + 1'b1, SJW_TQ);
                    resync     = 1'b1;
                end
                SEG_2: begin
                    resync = 1'b1;
                    if (rem <= SJW_TQ) begin
                        restart = 1'b1;
                    end else begin
                        seg2_len_n = seg2_len_q - SJW_TQ;
                    end
                end
                default: ;
            endcase
        end

        presc_d = tick ? '0 : presc_q + 1'b1;
        seg_d   = seg_q;
        tq_d    = tq_q;
        wrap    = 1'b0;
        if (tick) begin
            case (seg_q)
                SEG_SYNC: begin
                    seg_d = SEG_1;
                    tq_d  = '0;
                end
                SEG_1: begin
                    if (tq_q == seg1_len_n - 1'b1) begin
                        seg_d = SEG_2;
                        tq_d  = '0;
                    end else begin
                        tq_d = tq_q + 1'b1;
                    end
                end
                SEG_2: begin
                    if (tq_q == seg2_len_n - 1'b1) begin
                        seg_d = SEG_SYNC;
                        tq_d  = '0;
                        wrap  = 1'b1;
                    end else begin
                        tq_d = tq_q + 1'b1;
                    end
                end
                default: begin
                    seg_d = SEG_SYNC;
                    tq_d  = '0;
                end
            endcase
        end

        if (restart) begin
            seg_d   = SEG_SYNC;
            presc_d = '0;
            tq_d    = '0;
        end

        entering_sync = restart | wrap;
        seg1_len_d    = entering_sync ? SEG1_NOM : seg1_len_n;
        seg2_len_d    = entering_sync ? SEG2_NOM : seg2_len_n;

        // A late edge on the sample clock stretches SEG1; sp_done stops a second SP
        sp_done_d   = entering_sync ? 1'b0 : (sp_done_q | sp_q);
        sp_d        = (seg_d == SEG_1) && (presc_d == PRESC_MAX) &&
                      (tq_d == seg1_len_d - 1'b1) && !(sp_done_q | sp_q);
        bit_start_d = entering_sync;
        resync_d    = resync;
        synced_d    = handled ? 1'b1 : (sp_q ? 1'b0 : synced_q);
        sampled_d   = sp_q ? rx_s : sampled_q;
    end

    // All timing state and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_q       <= SEG_SYNC;
            presc_q     <= '0;
            tq_q        <= '0;
            seg1_len_q  <= SEG1_NOM;
            seg2_len_q  <= SEG2_NOM;
            synced_q    <= 1'b0;
            sp_done_q   <= 1'b0;
            sp_q        <= 1'b0;
            bit_start_q <= 1'b0;
            resync_q    <= 1'b0;
            sampled_q   <= RECESSIVE;
        end else begin
            seg_q       <= seg_d;
            presc_q     <= presc_d;
            tq_q        <= tq_d;
            seg1_len_q  <= seg1_len_d;
            seg2_len_q  <= seg2_len_d;
            synced_q    <= synced_d;
            sp_done_q   <= sp_done_d;
            sp_q        <= sp_d;
            bit_start_q <= bit_start_d;
            resync_q    <= resync_d;
            sampled_q   <= sampled_d;
        end
    end

    assign bus.SP           = sp_q;
    assign bus.sampled_bit  = sampled_q;
    assign bus.bit_start    = bit_start_q;
    assign bus.resync_event = resync_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: directed edge-placement table, hand-written reset / hard
// sync sequences, and randomized RX traffic against a bit-position reference model.
module tb_can_bit_timing;

    localparam int BRP   = 4;
    localparam int TSEG1 = 5;
    localparam int TSEG2 = 2;
    localparam int SJW   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    can_bit_timing_if bus ();

    can_bit_timing #(
        .BRP   (BRP),
        .TSEG1 (TSEG1),
        .TSEG2 (TSEG2),
        .SJW   (SJW)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the clock position inside the current bit and the
    // segment lengths in tq; segment and tq index follow by division.
    int m_pos = 0, m_s1 = TSEG1, m_s2 = TSEG2;
    bit m_synced = 0, m_spdone = 0, m_sp = 0, m_bs = 0, m_rs = 0, m_samp = 1;
    bit m_f1 = 1, m_f2 = 1, m_f3 = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_s1 = TSEG1; m_s2 = TSEG2;
            m_synced = 0; m_spdone = 0; m_sp = 0; m_bs = 0; m_rs = 0; m_samp = 1;
            m_f1 = 1; m_f2 = 1; m_f3 = 1;
        end else begin
            bit fe, restart, rs, handled, spdone;
            int seg, k, rem, ext;
            fe = m_f3 & ~m_f2;
            if (m_pos < BRP) begin
                seg = 0; k = 0;
            end else if (m_pos < BRP * (1 + m_s1)) begin
                seg = 1; k = (m_pos - BRP) / BRP;
            end else begin
                seg = 2; k = (m_pos - BRP * (1 + m_s1)) / BRP;
            end
            restart = 0; rs = 0; handled = 0;
            if (fe && bus.hard_sync_en) begin
                restart = 1; handled = 1;
            end else if (fe && !m_synced) begin
                handled = 1;
                if (seg == 1) begin
                    ext = (k + 1 < SJW) ? k + 1 : SJW;
                    m_s1 = TSEG1 + ext;
                    rs = 1;
                end else if (seg == 2) begin
                    rem = m_s2 - k;
                    rs = 1;
                    if (rem <= SJW) restart = 1;
                    else m_s2 = m_s2 - SJW;
                end
            end
            if (handled) m_synced = 1;
            else if (m_sp) m_synced = 0;
            if (m_sp) m_samp = m_f2;
            spdone = m_spdone | m_sp;
            if (restart || (m_pos + 1 == BRP * (1 + m_s1 + m_s2))) begin
                m_pos = 0; m_s1 = TSEG1; m_s2 = TSEG2; spdone = 0; m_bs = 1;
            end else begin
                m_pos = m_pos + 1; m_bs = 0;
            end
            m_rs = rs | restart;
            m_sp = !spdone && (m_pos == BRP * (1 + m_s1) - 1);
            m_spdone = spdone;
            m_f3 = m_f2; m_f2 = m_f1; m_f1 = bus.RX;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model {SP,bit_start,resync_event,sampled_bit}",
                int'({bus.SP, bus.bit_start, bus.resync_event, bus.sampled_bit}),
                int'({m_sp, m_bs, m_rs, m_samp}));
        end
    end

    int rs_total = 0;
    always @(negedge clk) if (bus.resync_event === 1'b1) rs_total++;

    function automatic logic sig(input int which);
        return (which == 0) ? bus.SP : bus.bit_start;
    endfunction

    // Advance cycle by cycle until the chosen strobe is seen; bounded
    task automatic cycles_until(input int which, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sig(which) !== 1'b1 && n < limit);
        if (sig(which) !== 1'b1) chk("wait timeout", 0, 1);
    endtask

    typedef struct {
        int d;    // bit position of the detected falling edge
        int d2;   // position of a second falling edge, -1 for none
        bit hs;   // hard_sync_en during the edge
        int len;  // expected bit length in clocks
        int sp;   // expected SP position, -1 for none
        int rs;   // expected resync_event pulses
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int idx);
        vec_t v;
        int n, len, sp_pos, sp_cnt, rs_cnt;
        v = vecs[idx];
        cycles_until(1, 200, n);
        cycles_until(1, 200, n);
        len = -1; sp_pos = -1; sp_cnt = 0; rs_cnt = 0;
        for (int p = 0; p < 80; p++) begin
            if (p > 0 && bus.resync_event === 1'b1) rs_cnt++;
            if (p > 0 && bus.bit_start === 1'b1) begin
                len = p;
                break;
            end
            if (bus.SP === 1'b1) begin
                sp_cnt++;
                if (sp_pos < 0) sp_pos = p;
            end
            if (p == v.d - 2) begin
                bus.RX = 1'b0;
                bus.hard_sync_en = v.hs;
            end
            if (p == v.d + 1) bus.hard_sync_en = 1'b0;
            if (p == v.d + 2) bus.RX = 1'b1;
            if (v.d2 >= 0 && p == v.d2 - 2) bus.RX = 1'b0;
            @(posedge clk); #1;
        end
        bus.RX = 1'b1;
        bus.hard_sync_en = 1'b0;
        chk($sformatf("vec%0d bit length", idx), len, v.len);
        chk($sformatf("vec%0d SP position", idx), sp_pos, v.sp);
        chk($sformatf("vec%0d SP count", idx), sp_cnt, (v.sp >= 0) ? 1 : 0);
        chk($sformatf("vec%0d resync count", idx), rs_cnt, v.rs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rs0;

        //          d   d2  hs  len  sp  rs
        vecs[0]  = '{2,  -1, 0, 32, 23, 0};  // SYNC_SEG edge, no adjustment
        vecs[1]  = '{12, -1, 0, 36, 27, 1};  // SEG1 tq 2: SEG1 stretched
        vecs[2]  = '{4,  14, 0, 36, 27, 1};  // SEG1 tq 0, second edge ignored
        vecs[3]  = '{23, -1, 0, 36, 23, 1};  // edge on the SP clock
        vecs[4]  = '{25, -1, 0, 28, 23, 1};  // SEG2 tq 0: SEG2 shortened
        vecs[5]  = '{29, -1, 0, 30, 23, 1};  // SEG2 tq 1: bit restarts
        vecs[6]  = '{10, -1, 1, 11, -1, 1};  // hard sync in SEG1
        vecs[7]  = '{2,  -1, 1, 3,  -1, 1};  // hard sync in SYNC_SEG
        vecs[8]  = '{20, -1, 1, 21, -1, 1};  // hard sync just before SP
        vecs[9]  = '{30, -1, 1, 31, 23, 1};  // hard sync in SEG2
        vecs[10] = '{12, 20, 0, 36, 27, 1};  // two edges, only first resyncs

        bus.RX = 1'b1;
        bus.hard_sync_en = 1'b0;
        @(posedge clk); #1;
        chk("reset SP", bus.SP, 0);
        chk("reset bit_start", bus.bit_start, 0);
        chk("reset resync_event", bus.resync_event, 0);
        chk("reset sampled_bit", bus.sampled_bit, 1);
        chk_en = 1'b1;

        // Idle bus after reset release: nominal timing
        rst_n = 1'b1;
        rs0 = rs_total;
        cycles_until(0, 100, n);
        chk("first SP after release", n, 23);
        cycles_until(0, 100, n);
        chk("SP period", n, 32);
        cycles_until(1, 100, n);
        cycles_until(1, 100, n);
        chk("bit_start period", n, 32);
        chk("idle sampled_bit", bus.sampled_bit, 1);
        chk("idle resync count", rs_total - rs0, 0);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Hard sync: strobes one clock after edge detection, SP 23 clocks later
        cycles_until(1, 200, n);
        repeat (5) begin @(posedge clk); #1; end
        bus.hard_sync_en = 1'b1;
        bus.RX = 1'b0;
        cycles_until(1, 100, n);
        chk("hard sync latency", n, 3);
        chk("hard sync resync_event", bus.resync_event, 1);
        bus.hard_sync_en = 1'b0;
        cycles_until(0, 100, n);
        chk("SP after hard sync", n, 23);
        @(posedge clk); #1;
        chk("sampled_bit dominant", bus.sampled_bit, 0);

        // Reset in the middle of SEG1 with sampled_bit dominant
        cycles_until(1, 100, n);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mid-bit reset SP", bus.SP, 0);
        chk("mid-bit reset bit_start", bus.bit_start, 0);
        chk("mid-bit reset sampled_bit", bus.sampled_bit, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles_until(0, 100, n);
        chk("SP after mid-bit reset", n, 23);
        @(posedge clk); #1;
        chk("sampled_bit after mid-bit reset", bus.sampled_bit, 0);
        bus.RX = 1'b1;

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(15) == 0) bus.RX = ~bus.RX;
            if ($urandom_range(63) == 0) bus.hard_sync_en = ~bus.hard_sync_en;
            if ($urandom_range(1499) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
